check_time_and_return: RTL and testbench

- Sequential neighbour of the vending machine's combinational total/item stage.
- Owns the inactivity timer (`wait_time`) and generates `o_return_coin`, one coin per cycle, on timeout or on a return request.
- Both outputs feed back into the total calculation, which subtracts the returned coin value from `current_total`.
- `current_total` is held by the top-level state register and is updated every clock edge.

---
 rtl/check_time_and_return.sv | 117 +++++++++++
 tb/tb_check_time_and_return.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/check_time_and_return.sv
// Inactivity timer and coin-return sequencer for the vending machine.
// Returns the balance one coin per cycle, largest denomination first, on timeout or on request.
module check_time_and_return #(
  parameter int kNumCoins  = 3,
  parameter int kNumItems  = 4,
  parameter int kTotalBits = 31,
  parameter int kWaitTime  = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [kNumCoins-1:0]        i_input_coin,
  input  logic [kNumItems-1:0]        o_output_item,
  input  logic                        i_trigger_return,
  input  logic [kNumCoins-1:0][31:0]  coin_value,
  input  logic [kTotalBits-1:0]       current_total,
  output logic [31:0]                 wait_time,
  output logic [kNumCoins-1:0]        o_return_coin
);

  localparam int kCmpBits = (kTotalBits > 32) ? kTotalBits : 32;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    RETURN
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            wait_time_q, wait_time_d;
  logic [kNumCoins-1:0]   return_coin_q, return_coin_d;

  logic                   activity;
  logic [kTotalBits-1:0]  returned_value;
  logic [kTotalBits-1:0]  remaining;
  logic [kNumCoins-1:0]   next_coin;

  assign activity = (|i_input_coin) | (|o_output_item);

  // The coin on the output has not yet been subtracted by the total stage,
  // so discount it here to avoid paying it out twice.
  always_comb begin
    returned_value = '0;
    for (int unsigned i = 0; i < kNumCoins; i++) begin
      if (return_coin_q[i]) begin
        returned_value = kTotalBits'(coin_value[i]);
      end
    end
    remaining = current_total - returned_value;
  end

  // Later (larger) denominations overwrite earlier ones: highest fitting coin wins.
  always_comb begin
    next_coin = '0;
    for (int unsigned i = 0; i < kNumCoins; i++) begin
      if (kCmpBits'(coin_value[i]) <= kCmpBits'(remaining)) begin
        next_coin    = '0;
        next_coin[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_time_d   = wait_time_q;
    return_coin_d = '0;
    unique case (state_q)
      IDLE: begin
        wait_time_d = '0;
        if (activity) begin
          wait_time_d = 32'(kWaitTime);
          state_d     = COUNT;
        end else if (i_trigger_return && (current_total != '0)) begin
          return_coin_d = next_coin;
          state_d       = (next_coin != '0) ? RETURN : IDLE;
        end
      end
      COUNT: begin
        if (activity) begin
          wait_time_d = 32'(kWaitTime);
        end else if (i_trigger_return || (wait_time_q == '0)) begin
          return_coin_d = next_coin;
          wait_time_d   = '0;
          state_d       = (next_coin != '0) ? RETURN : IDLE;
        end else begin
          wait_time_d = wait_time_q - 32'd1;
        end
      end
      RETURN: begin
        wait_time_d   = '0;
        return_coin_d = next_coin;
        if (next_coin == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        wait_time_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wait_time_q   <= '0;
      return_coin_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_time_q   <= wait_time_d;
      return_coin_q <= return_coin_d;
    end
  end

  assign wait_time     = wait_time_q;
  assign o_return_coin = return_coin_q;

endmodule

// File: tb/tb_check_time_and_return.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural vending model.
module tb_check_time_and_return;

  localparam int kNumCoins  = 3;
  localparam int kNumItems  = 4;
  localparam int kTotalBits = 31;
  localparam int kWaitTime  = 10;

  logic                        clk;
  logic                        reset;
  logic [kNumCoins-1:0]        i_input_coin;
  logic [kNumItems-1:0]        o_output_item;
  logic                        i_trigger_return;
  logic [kNumCoins-1:0][31:0]  coin_value;
  logic [kTotalBits-1:0]       current_total;
  logic [31:0]                 wait_time;
  logic [kNumCoins-1:0]        o_return_coin;

  int checks = 0;
  int errors = 0;

  // Model: balance, countdown, and the coin the machine is paying out.
  int unsigned m_total;
  int unsigned m_wait;
  logic [2:0]  m_ret;
  bit          m_timing;
  bit          m_paying;

  int unsigned cv [3] = '{100, 500, 1000};

  check_time_and_return #(
    .kNumCoins (kNumCoins),
    .kNumItems (kNumItems),
    .kTotalBits(kTotalBits),
    .kWaitTime (kWaitTime)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_input_coin    (i_input_coin),
    .o_output_item   (o_output_item),
    .i_trigger_return(i_trigger_return),
    .coin_value      (coin_value),
    .current_total   (current_total),
    .wait_time       (wait_time),
    .o_return_coin   (o_return_coin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned coins_worth(input logic [2:0] c);
    int unsigned s = 0;
    for (int i = 0; i < 3; i++) if (c[i]) s += cv[i];
    return s;
  endfunction

  // Greedy change-giving: largest denomination that still fits.
  function automatic logic [2:0] largest_fit(input int unsigned amount);
    if (amount >= 1000) return 3'b100;
    if (amount >= 500)  return 3'b010;
    if (amount >= 100)  return 3'b001;
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_wait   = 0;
    m_ret    = '0;
    m_timing = 0;
    m_paying = 0;
  endtask

  // Drive one cycle of stimulus, advance the model, and compare both outputs.
  task automatic step(input string name, input logic [2:0] coin, input logic [3:0] item,
                      input logic trig);
    bit           act;
    int unsigned  left;
    logic [2:0]   pick;
    int unsigned  new_total;
    i_input_coin     = coin;
    o_output_item    = item;
    i_trigger_return = trig;
    current_total    = kTotalBits'(m_total);
    act  = (coin != 0) || (item != 0);
    left = m_total - coins_worth(m_ret);
    pick = largest_fit(left);
    new_total = m_total + coins_worth(coin) - coins_worth(m_ret);
    if (m_paying) begin
      m_ret = pick;
      m_paying = (pick != 0);
    end else if (act) begin
      m_timing = 1;
      m_wait = kWaitTime;
      m_ret = 0;
    end else if ((m_timing && (trig || m_wait == 0)) || (!m_timing && trig && m_total > 0)) begin
      m_timing = 0;
      m_wait = 0;
      m_ret = pick;
      m_paying = (pick != 0);
    end else begin
      m_ret = 0;
      if (m_timing) m_wait = m_wait - 1;
    end
    m_total = new_total;
    @(posedge clk);
    #1;
    current_total = kTotalBits'(m_total);
    checks++;
    if (wait_time !== m_wait) begin
      errors++;
      $display("FAIL %s wait_time got %0d expected %0d", name, wait_time, m_wait);
    end
    checks++;
    if (o_return_coin !== m_ret) begin
      errors++;
      $display("FAIL %s o_return_coin got %b expected %b", name, o_return_coin, m_ret);
    end
  endtask

  task automatic idle_steps(input string name, input int n);
    for (int i = 0; i < n; i++) step(name, 3'b000, 4'b0000, 1'b0);
  endtask

  task automatic test_reset();
    checks++;
    if (wait_time !== 32'd0 || o_return_coin !== 3'b000) begin
      errors++;
      $display("FAIL reset_state wait=%0d coin=%b expected 0/000", wait_time, o_return_coin);
    end
    reset = 1'b0;
    m_total = 1600;
    step("reset_setup", 3'b000, 4'b0000, 1'b1);
    checks++;
    if (o_return_coin !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid_return_pre coin got %b expected 100", o_return_coin);
    end
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (o_return_coin !== 3'b000 || wait_time !== 32'd0) begin
      errors++;
      $display("FAIL reset_async wait=%0d coin=%b expected 0/000", wait_time, o_return_coin);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_steps("reset_after_idle", 4);
    m_total = 0;
  endtask

  task automatic test_timeout();
    step("timeout_insert", 3'b010, 4'b0000, 1'b0);
    checks++;
    if (wait_time !== 32'd10 || m_total != 500) begin
      errors++;
      $display("FAIL timeout_reload wait got %0d expected 10", wait_time);
    end
    idle_steps("timeout_count", 10);
    checks++;
    if (wait_time !== 32'd0) begin
      errors++;
      $display("FAIL timeout_zero wait got %0d expected 0", wait_time);
    end
    step("timeout_coin", 3'b000, 4'b0000, 1'b0);
    checks++;
    if (o_return_coin !== 3'b010) begin
      errors++;
      $display("FAIL timeout_first_coin got %b expected 010", o_return_coin);
    end
    idle_steps("timeout_end", 3);
    checks++;
    if (m_total != 0 || o_return_coin !== 3'b000) begin
      errors++;
      $display("FAIL timeout_drain total %0d coin %b expected 0/000", m_total, o_return_coin);
    end
  endtask

  task automatic test_trigger_return();
    logic [2:0] seen [3];
    m_total = 1600;
    step("trig_1600", 3'b000, 4'b0000, 1'b1);
    seen[0] = o_return_coin;
    step("trig_seq", 3'b000, 4'b0000, 1'b0);
    seen[1] = o_return_coin;
    step("trig_seq", 3'b000, 4'b0000, 1'b0);
    seen[2] = o_return_coin;
    step("trig_seq", 3'b000, 4'b0000, 1'b0);
    checks++;
    if (seen[0] !== 3'b100 || seen[1] !== 3'b010 || seen[2] !== 3'b001 || o_return_coin !== 3'b000) begin
      errors++;
      $display("FAIL trig_sequence got %b %b %b %b expected 100 010 001 000",
               seen[0], seen[1], seen[2], o_return_coin);
    end
    idle_steps("trig_idle", 2);
  endtask

  task automatic test_restart();
    step("restart_insert", 3'b001, 4'b0000, 1'b0);
    idle_steps("restart_count", 7);
    checks++;
    if (wait_time !== 32'd3) begin
      errors++;
      $display("FAIL restart_at3 wait got %0d expected 3", wait_time);
    end
    step("restart_reload", 3'b001, 4'b0000, 1'b0);
    checks++;
    if (wait_time !== 32'd10) begin
      errors++;
      $display("FAIL restart_reload wait got %0d expected 10", wait_time);
    end
    idle_steps("restart_wait", 10);
    step("restart_coin", 3'b000, 4'b0000, 1'b0);
    checks++;
    if (o_return_coin !== 3'b001) begin
      errors++;
      $display("FAIL restart_coin got %b expected 001", o_return_coin);
    end
    idle_steps("restart_drain", 3);
  endtask

  task automatic test_zero_trigger();
    m_total = 0;
    step("zero_trig", 3'b000, 4'b0000, 1'b1);
    idle_steps("zero_after", 2);
    checks++;
    if (o_return_coin !== 3'b000 || wait_time !== 32'd0) begin
      errors++;
      $display("FAIL zero_trigger coin %b wait %0d expected 000/0", o_return_coin, wait_time);
    end
  endtask

  task automatic test_residue_and_late_insert();
    m_total = 650;
    step("res_trig", 3'b000, 4'b0000, 1'b1);
    step("res_first", 3'b000, 4'b0000, 1'b0);
    step("res_second", 3'b000, 4'b0000, 1'b0);
    checks++;
    if (m_total != 50 || o_return_coin !== 3'b000) begin
      errors++;
      $display("FAIL residue total %0d coin %b expected 50/000", m_total, o_return_coin);
    end
    idle_steps("res_idle", 2);
    m_total = 650;
    step("late_trig", 3'b000, 4'b0000, 1'b1);
    step("late_insert", 3'b100, 4'b0000, 1'b0);
    checks++;
    if (o_return_coin !== 3'b001) begin
      errors++;
      $display("FAIL late_small got %b expected 001", o_return_coin);
    end
    step("late_extra", 3'b000, 4'b0000, 1'b0);
    checks++;
    if (o_return_coin !== 3'b100) begin
      errors++;
      $display("FAIL late_extra got %b expected 100", o_return_coin);
    end
    idle_steps("late_end", 3);
    checks++;
    if (m_total != 50 || wait_time !== 32'd0) begin
      errors++;
      $display("FAIL late_residue total %0d wait %0d expected 50/0", m_total, wait_time);
    end
    m_total = 0;
    idle_steps("late_clear", 1);
  endtask

  task automatic test_random();
    logic [2:0] c;
    logic [3:0] it;
    logic       tr;
    for (int n = 0; n < 400; n++) begin
      c  = ($urandom_range(0, 7) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
      it = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      tr = ($urandom_range(0, 19) == 0);
      step("random", c, it, tr);
    end
  endtask

  initial begin
    coin_value       = {32'd1000, 32'd500, 32'd100};
    reset            = 1'b1;
    i_input_coin     = '0;
    o_output_item    = '0;
    i_trigger_return = 1'b0;
    current_total    = '0;
    m_total          = 0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_timeout();
    test_trigger_return();
    test_restart();
    test_zero_trigger();
    test_residue_and_late_insert();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
